// File: rtl/counter_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// counter_ctrl_pkg
// Shared types and constants for the counter_ctrl sequencer/arbiter and its
// embedded up/down modulo counter.
//   state_t      : controller FSM states (IDLE, RUN, DONE)
//   OWNER_A/B    : requester encodings used for owner and last-winner
//   DIR_UP/DOWN  : counter direction encodings
//   pick_winner  : round-robin tie-break between the two requesters
// -----------------------------------------------------------------------------
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OWNER_A  = 1'b0;
    localparam logic OWNER_B  = 1'b1;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // A lone requester always wins. On a tie, the requester that did not win
    // last time wins, so two permanently-requesting sources alternate.
    function automatic logic pick_winner(input logic req_a,
                                         input logic req_b,
                                         input logic last_winner);
        if (req_a && req_b)
            return ~last_winner;
        else if (req_b)
            return OWNER_B;
        else
            return OWNER_A;
    endfunction

endpackage

// File: rtl/counter_ctrl_updown_counter.sv
// -----------------------------------------------------------------------------
// mod_updown_counter
// Modulo up/down counter over 0..COUNT_SIZE, wrapping in both directions.
//   clk   : clock, rising edge
//   clear : asynchronous active-high reset, forces qd to 0
//   en    : step once on this edge
//   dir   : 1 = up, 0 = down
//   qd    : counter value
//   wrap  : high in the cycle whose closing edge wraps the counter
//           (COUNT_SIZE -> 0 going up, 0 -> COUNT_SIZE going down)
// -----------------------------------------------------------------------------
module mod_updown_counter
    import counter_ctrl_pkg::*;
#(
    parameter int COUNT_SIZE = 10
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       en,
    input  logic       dir,
    output logic [7:0] qd,
    output logic       wrap
);

    localparam logic [7:0] TOP = 8'(COUNT_SIZE);

    logic at_up_edge;
    logic at_down_edge;

    // NOTE: combinational logic assigns every output on every path so no
    // latch is inferred.
    always_comb begin
        at_up_edge   = (qd == TOP);
        at_down_edge = (qd == 8'd0);
        wrap         = en && ((dir == DIR_UP) ? at_up_edge : at_down_edge);
    end

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            qd <= 8'd0;
        end else if (en) begin
            if (dir == DIR_UP)
                qd <= at_up_edge ? 8'd0 : qd + 8'd1;
            else
                qd <= at_down_edge ? TOP : qd - 8'd1;
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// -----------------------------------------------------------------------------
// counter_ctrl
// Round-robin sequencer for a shared up/down modulo counter. Two requesters
// (A, B) each submit a job of N steps in one direction; one job is granted
// at a time and the counter is stepped exactly N times, then done pulses.
//   clk                  : clock, rising edge
//   clear                : asynchronous active-high reset
//   req_a/dir_a/steps_a  : requester A job (dir 1 = up), held until gnt_a
//   req_b/dir_b/steps_b  : requester B job, held until gnt_b
//   gnt_a, gnt_b         : one-cycle grant pulses
//   busy                 : high while a job is in RUN or DONE
//   done                 : one-cycle pulse when a job finishes
//   owner                : 0 = A, 1 = B; current or last granted requester
//   qd                   : counter value, persists across jobs
//   wraps                : (WRAP_CNT_EN only) wrap events in the current job,
//                          saturating at 255, cleared on grant
// Optional feature macro: WRAP_CNT_EN
// -----------------------------------------------------------------------------
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int COUNT_SIZE = 10,
    parameter int STEP_W     = 8
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              req_a,
    input  logic              dir_a,
    input  logic [STEP_W-1:0] steps_a,
    output logic              gnt_a,
    input  logic              req_b,
    input  logic              dir_b,
    input  logic [STEP_W-1:0] steps_b,
    output logic              gnt_b,
    output logic              busy,
    output logic              done,
    output logic              owner,
    output logic [7:0]        qd
`ifdef WRAP_CNT_EN
    ,
    output logic [7:0]        wraps
`endif
);

    state_t            state;
    logic [STEP_W-1:0] rem;
    logic              run_dir;
    logic              last_winner;

    logic              grant;
    logic              winner;
    logic              sel_dir;
    logic [STEP_W-1:0] sel_steps;
    logic              step_en;
    logic              wrap_stb;

    always_comb begin
        grant     = (state == IDLE) && (req_a || req_b);
        winner    = pick_winner(req_a, req_b, last_winner);
        sel_dir   = (winner == OWNER_B) ? dir_b   : dir_a;
        sel_steps = (winner == OWNER_B) ? steps_b : steps_a;
        step_en   = (state == RUN);
    end

    mod_updown_counter #(
        .COUNT_SIZE (COUNT_SIZE)
    ) u_counter (
        .clk   (clk),
        .clear (clear),
        .en    (step_en),
        .dir   (run_dir),
        .qd    (qd),
        .wrap  (wrap_stb)
    );

    // NOTE: clear is asynchronous; every control flop has a defined reset
    // value so an abort mid-job leaves no stale done/gnt pulse behind.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state       <= IDLE;
            rem         <= '0;
            run_dir     <= DIR_UP;
            last_winner <= OWNER_B;
            owner       <= OWNER_A;
            gnt_a       <= 1'b0;
            gnt_b       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            gnt_a <= 1'b0;
            gnt_b <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner       <= winner;
                        last_winner <= winner;
                        gnt_a       <= (winner == OWNER_A);
                        gnt_b       <= (winner == OWNER_B);
                        run_dir     <= sel_dir;
                        rem         <= sel_steps;
                        busy        <= 1'b1;
                        // A zero-step job skips RUN; gnt and done coincide.
                        if (sel_steps == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem <= rem - STEP_W'(1);
                    if (rem == STEP_W'(1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef WRAP_CNT_EN
    always_ff @(posedge clk or posedge clear) begin
        if (clear)
            wraps <= 8'd0;
        else if (grant)
            wraps <= 8'd0;
        else if (wrap_stb && (wraps != 8'hFF))
            wraps <= wraps + 8'd1;
    end
`else
    logic unused_wrap;
    assign unused_wrap = wrap_stb;
`endif

endmodule

// File: tb/tb_counter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_counter_ctrl
// Directed self-checking bench for counter_ctrl (COUNT_SIZE = 10, STEP_W = 8).
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// Define WRAP_CNT_EN to also exercise the wraps output.
// -----------------------------------------------------------------------------
module tb_counter_ctrl;

    localparam int COUNT_SIZE = 10;
    localparam int STEP_W     = 8;

    logic              clk = 1'b0;
    logic              clear;
    logic              req_a, dir_a, req_b, dir_b;
    logic [STEP_W-1:0] steps_a, steps_b;
    logic              gnt_a, gnt_b, busy, done, owner;
    logic [7:0]        qd;
`ifdef WRAP_CNT_EN
    logic [7:0]        wraps;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    counter_ctrl #(
        .COUNT_SIZE (COUNT_SIZE),
        .STEP_W     (STEP_W)
    ) dut (
        .clk     (clk),
        .clear   (clear),
        .req_a   (req_a),
        .dir_a   (dir_a),
        .steps_a (steps_a),
        .gnt_a   (gnt_a),
        .req_b   (req_b),
        .dir_b   (dir_b),
        .steps_b (steps_b),
        .gnt_b   (gnt_b),
        .busy    (busy),
        .done    (done),
        .owner   (owner),
        .qd      (qd)
`ifdef WRAP_CNT_EN
        ,
        .wraps   (wraps)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs a single-requester job of n > 0 steps and checks grant, completion
    // and the final counter value.
    task automatic run_job(input logic is_b, input logic d, input int n,
                           input logic [7:0] exp_final);
        if (is_b) begin
            req_b = 1'b1; dir_b = d; steps_b = STEP_W'(n);
        end else begin
            req_a = 1'b1; dir_a = d; steps_a = STEP_W'(n);
        end
        step();
        check("job_gnt", is_b ? gnt_b : gnt_a, 1);
        req_a = 1'b0; req_b = 1'b0;
        repeat (n) step();
        check("job_done", done, 1);
        check("job_qd", qd, exp_final);
        step();
        check("job_idle", busy, 0);
    endtask

    logic [11:0] pat_ga, pat_gb, pat_busy;
    logic [7:0]  exp_qd [12];

    initial begin
        clear = 1'b1;
        req_a = 1'b0; dir_a = 1'b1; steps_a = '0;
        req_b = 1'b0; dir_b = 1'b0; steps_b = '0;
        #3;
        // ---------------- reset state ----------------
        check("rst_qd", qd, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_gnt", {gnt_a, gnt_b}, 0);
        check("rst_owner", owner, 0);
        step();
        clear = 1'b0;
        step();
        check("rst_idle_busy", busy, 0);

        // ---------------- A up N=3 ----------------
        req_a = 1'b1; dir_a = 1'b1; steps_a = 8'd3;
        step();
        check("t1_gnt_a", gnt_a, 1);
        check("t1_gnt_b", gnt_b, 0);
        check("t1_busy", busy, 1);
        check("t1_owner", owner, 0);
        check("t1_qd0", qd, 0);
        req_a = 1'b0;
        step();
        check("t1_qd1", qd, 1);
        check("t1_gnt_pulse", gnt_a, 0);
        step();
        check("t1_qd2", qd, 2);
        check("t1_no_done", done, 0);
        step();
        check("t1_qd3", qd, 3);
        check("t1_done", done, 1);
        check("t1_busy_done", busy, 1);
        step();
        check("t1_done_pulse", done, 0);
        check("t1_busy_low", busy, 0);
        check("t1_qd_hold", qd, 3);

        // ---------------- wrap up from 9 ----------------
        run_job(1'b0, 1'b1, 6, 8'd9);
        req_a = 1'b1; dir_a = 1'b1; steps_a = 8'd4;
        step();
        check("t2_gnt_a", gnt_a, 1);
        req_a = 1'b0;
        step();
        check("t2_qd10", qd, 10);
        step();
        check("t2_qd0", qd, 0);
        step();
        check("t2_qd1", qd, 1);
        step();
        check("t2_qd2", qd, 2);
        check("t2_done", done, 1);
`ifdef WRAP_CNT_EN
        check("t2_wraps", wraps, 1);
`endif
        step();
        check("t2_done_pulse", done, 0);

        // ---------------- B down from 0 ----------------
        run_job(1'b0, 1'b0, 2, 8'd0);
        req_b = 1'b1; dir_b = 1'b0; steps_b = 8'd2;
        step();
        check("t3_gnt_b", gnt_b, 1);
        check("t3_gnt_a", gnt_a, 0);
        check("t3_owner", owner, 1);
        req_b = 1'b0;
        step();
        check("t3_qd10", qd, 10);
        check("t3_no_done", done, 0);
        step();
        check("t3_qd9", qd, 9);
        check("t3_done", done, 1);
`ifdef WRAP_CNT_EN
        check("t3_wraps", wraps, 1);
`endif
        step();
        check("t3_done_once", done, 0);
        check("t3_owner_hold", owner, 1);

        // ---------------- both held high: A,B,A,B ----------------
        // Step i (1-based) maps to bit i-1. Grants every third edge, with the
        // edge before each grant spent in IDLE (busy low).
        pat_ga   = 12'b000001000001;
        pat_gb   = 12'b001000001000;
        pat_busy = 12'b011011011011;
        exp_qd   = '{8'd9, 8'd10, 8'd10, 8'd10, 8'd9, 8'd9,
                     8'd9, 8'd10, 8'd10, 8'd10, 8'd9, 8'd9};
        req_a = 1'b1; dir_a = 1'b1; steps_a = 8'd1;
        req_b = 1'b1; dir_b = 1'b0; steps_b = 8'd1;
        for (int i = 0; i < 12; i++) begin
            step();
            check("rr_gnt_a", gnt_a, pat_ga[i]);
            check("rr_gnt_b", gnt_b, pat_gb[i]);
            check("rr_busy", busy, pat_busy[i]);
            check("rr_qd", qd, exp_qd[i]);
        end
        req_a = 1'b0; req_b = 1'b0;
        check("rr_owner", owner, 1);

        // ---------------- A N=0 ----------------
        req_a = 1'b1; dir_a = 1'b1; steps_a = 8'd0;
        step();
        check("t5_gnt_a", gnt_a, 1);
        check("t5_done", done, 1);
        check("t5_busy", busy, 1);
        check("t5_owner", owner, 0);
        check("t5_qd", qd, 9);
`ifdef WRAP_CNT_EN
        check("t5_wraps", wraps, 0);
`endif
        req_a = 1'b0;
        step();
        check("t5_idle_busy", busy, 0);
        check("t5_idle_done", done, 0);
        check("t5_idle_gnt", gnt_a, 0);
        check("t5_qd_hold", qd, 9);

        // ---------------- clear during RUN ----------------
        req_a = 1'b1; dir_a = 1'b1; steps_a = 8'd8;
        step();
        check("t6_gnt_a", gnt_a, 1);
        req_a = 1'b0;
        step();
        step();
        step();
        check("t6_qd_before", qd, 1);
        check("t6_busy_before", busy, 1);
        clear = 1'b1;
        #1;
        check("t6_abort_qd", qd, 0);
        check("t6_abort_busy", busy, 0);
        check("t6_abort_done", done, 0);
        check("t6_abort_owner", owner, 0);
`ifdef WRAP_CNT_EN
        check("t6_abort_wraps", wraps, 0);
`endif
        step();
        clear = 1'b0;
        step();
        check("t6_no_done", done, 0);
        step();
        check("t6_still_idle", {busy, done}, 0);
        // Last winner was reset to B, so A must win a tie now.
        req_a = 1'b1; dir_a = 1'b1; steps_a = 8'd2;
        req_b = 1'b1; dir_b = 1'b0; steps_b = 8'd5;
        step();
        check("t6_tie_gnt_a", gnt_a, 1);
        check("t6_tie_gnt_b", gnt_b, 0);
        req_a = 1'b0; req_b = 1'b0;
        step();
        check("t6_qd1", qd, 1);
        step();
        check("t6_qd2", qd, 2);
        check("t6_done", done, 1);
        step();
        check("t6_end_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
